// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispenser: state encoding,
// coin codes/values and datapath widths.
package vend_pkg;

  localparam int MONEY_W = 7;
  localparam int TYPE_W  = 3;
  localparam int AMT_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PULSE  = 3'd1,
    ST_GAP    = 3'd2,
    ST_CHANGE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_5    = 2'b10;
  localparam logic [1:0] COIN_10   = 2'b11;

  localparam logic [MONEY_W-1:0] VAL_1  = 7'd1;
  localparam logic [MONEY_W-1:0] VAL_5  = 7'd5;
  localparam logic [MONEY_W-1:0] VAL_10 = 7'd10;

endpackage

// File: rtl/vend_change_gen.sv
// Change remainder register with greedy 10/5/1 coin selection; one coin
// is consumed per step, and last_o flags the coin that empties the register.
module vend_change_gen
  import vend_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [MONEY_W-1:0] load_value_i,
  input  logic               step_i,
  output logic [1:0]         coin_code_o,
  output logic               empty_o,
  output logic               last_o
);

  logic [MONEY_W-1:0] rem_q, rem_d;
  logic [MONEY_W-1:0] coin_val;

  always_comb begin
    coin_code_o = COIN_NONE;
    coin_val    = '0;
    if (rem_q >= VAL_10) begin
      coin_code_o = COIN_10;
      coin_val    = VAL_10;
    end else if (rem_q >= VAL_5) begin
      coin_code_o = COIN_5;
      coin_val    = VAL_5;
    end else if (rem_q != '0) begin
      coin_code_o = COIN_1;
      coin_val    = VAL_1;
    end
  end

  // coin_val never exceeds rem_q, so the subtraction cannot wrap
  always_comb begin
    rem_d = rem_q;
    if (load_i)
      rem_d = load_value_i;
    else if (step_i)
      rem_d = rem_q - coin_val;
  end

  assign empty_o = (rem_q == '0);
  assign last_o  = !empty_o && (rem_q == coin_val);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rem_q <= '0;
    else
      rem_q <= rem_d;
  end

endmodule

// File: rtl/vend_dispenser.sv
// Vend command consumer: pulses the product motor per item, then pays change.
// Define VEND_CHANGE_EN to include the CHANGE phase; otherwise no coins are paid.
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vend_valid,
  output logic               vend_ready,
  input  logic [TYPE_W-1:0]  vend_type,
  input  logic [AMT_W-1:0]   vend_amount,
  input  logic [MONEY_W-1:0] vend_change,
  output logic [TYPE_W-1:0]  motor_sel,
  output logic               motor_pulse,
  output logic               coin_strobe,
  output logic [1:0]         coin_code,
  output logic               busy,
  output logic               done
);

  localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [AMT_W-1:0]   items_q, items_d;
  logic [TYPE_W-1:0]  type_q, type_d;

  logic               chg_load;
  logic               chg_step;
  logic [1:0]         chg_code;
  logic               chg_empty;
  logic               chg_last;
  logic               chg_pending;

`ifdef VEND_CHANGE_EN
  vend_change_gen u_change_gen (
    .clk          (clk),
    .rst          (rst),
    .load_i       (chg_load),
    .load_value_i (vend_change),
    .step_i       (chg_step),
    .coin_code_o  (chg_code),
    .empty_o      (chg_empty),
    .last_o       (chg_last)
  );
  assign chg_pending = (vend_change != '0);
`else
  logic unused_change;
  assign unused_change = ^{vend_change, chg_load, chg_step};
  assign chg_code      = COIN_NONE;
  assign chg_empty     = 1'b1;
  assign chg_last      = 1'b0;
  assign chg_pending   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    items_d     = items_q;
    type_d      = type_q;
    chg_load    = 1'b0;
    chg_step    = 1'b0;
    vend_ready  = 1'b0;
    motor_sel   = '0;
    motor_pulse = 1'b0;
    coin_strobe = 1'b0;
    coin_code   = COIN_NONE;
    done        = 1'b0;
    busy        = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        vend_ready = 1'b1;
        if (vend_valid) begin
          type_d   = vend_type;
          items_d  = vend_amount;
          cnt_d    = '0;
          chg_load = 1'b1;
          if (vend_amount != '0)
            state_d = ST_PULSE;
          else if (chg_pending)
            state_d = ST_CHANGE;
          else
            state_d = ST_DONE;
        end
      end
      ST_PULSE: begin
        motor_pulse = 1'b1;
        motor_sel   = type_q;
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_GAP: begin
        motor_sel = type_q;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          items_d = items_q - 1'b1;
          if (items_q > 1)
            state_d = ST_PULSE;
          else if (!chg_empty)
            state_d = ST_CHANGE;
          else
            state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_CHANGE: begin
        coin_strobe = 1'b1;
        coin_code   = chg_code;
        chg_step    = 1'b1;
        if (chg_last)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      items_q <= '0;
      type_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      items_q <= items_d;
      type_q  <= type_d;
    end
  end

endmodule

// File: doc/vend_dispenser.md
# vend_dispenser

Output-side dispenser of the vending machine. It accepts one vend command per transaction from the `Main` core's decision logic over a valid/ready handshake. It then drives the product motor for the requested number of items and pays out the customer's change as a sequence of coin strobes. It is the consumer of the purchase data that `Main` takes in from the customer panel (`customer_money`, `supply_type`, `customer_amount`).

## Interface
- `PULSE_CYCLES`, default 4: motor pulse width per item, in cycles; legal range 1..15.
- `GAP_CYCLES`, default 2: idle cycles after each motor pulse; legal range 1..15.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `vend_valid`  in  1  a command is presented.
- `vend_ready`  out  1  dispenser can accept a command.
- `vend_type`  in  3  product slot 0..7.
- `vend_amount`  in  4  item count 0..15.
- `vend_change`  in  7  change owed, money units 0..127.
- `motor_sel`  out  3  slot driven by the motor.
- `motor_pulse`  out  1  motor drive.
- `coin_strobe`  out  1  one coin released this cycle.
- `coin_code`  out  2  coin value: 01 = 1 unit, 10 = 5 units, 11 = 10 units, 00 = none.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: `IDLE`, `PULSE`, `GAP`, `CHANGE`, `DONE`.
- **IDLE**
  - `vend_ready` = 1.
  - On `vend_valid && vend_ready`: capture type, amount and change.
  - Next state: `PULSE` if amount≠0; else `CHANGE` if change≠0; else `DONE`.
- **PULSE**
  - `motor_pulse` = 1 and `motor_sel` = captured type for exactly `PULSE_CYCLES` cycles.
  - Then go to `GAP`.
- **GAP**
  - `motor_pulse` = 0 for `GAP_CYCLES` cycles.
  - On the last cycle, decrement the item count.
  - Next state: `PULSE` if items remain; else `CHANGE` if change≠0; else `DONE`.
- **CHANGE**
  - One coin per cycle with `coin_strobe` = 1, chosen greedily:
    - remainder ≥10 → code 11, subtract 10;
    - else remainder ≥5 → code 10, subtract 5;
    - else code 01, subtract 1.
  - The cycle that brings the remainder to 0 is followed by `DONE`.
- **DONE**
  - `done` = 1 for one cycle, then return to `IDLE`.
- Outputs:
  - `busy` = 1 in every state except `IDLE`.
  - `vend_ready` = 0 in every state except `IDLE`.
- Command inputs are ignored while busy; an asserted `vend_valid` waits for `IDLE`.
- Change remainder register is 7 bits and never underflows; the greedy choice guarantees this.
- `motor_sel` holds the captured type during `PULSE`/`GAP`; it is 0 in all other states.

## Timing
- Reset values:
  - State = `IDLE`, all counters 0.
  - `vend_ready` = 1.
  - `motor_pulse`, `motor_sel`, `coin_strobe`, `coin_code`, `busy`, `done` = 0.
- All outputs are registered-state decodes (Moore); no input-to-output combinational path.
- Counting from cycle 0 as the first cycle after the accept edge:
  - first `motor_pulse` is in cycle 0;
  - `done` is in cycle A·(PULSE_CYCLES+GAP_CYCLES) + K, where A = amount and K = number of coins.
- Back-to-back transactions: the next accept can occur in the `IDLE` cycle right after `DONE`, so there is a minimum one-cycle gap.
- Reset asserted mid-transaction:
  - all outputs drop asynchronously to reset values;
  - remaining items and change are discarded;
  - no `done` is produced.
- Amount 0 and change 0: `done` is in cycle 0.

## Configuration
- `VEND_CHANGE_EN` defined:
  - change is captured and `CHANGE` is implemented as above.
- `VEND_CHANGE_EN` undefined:
  - `vend_change` is ignored and `CHANGE` is absent;
  - `coin_strobe` and `coin_code` are tied 0;
  - after the last item, or immediately for amount 0, go to `DONE`.

## Structure
- Shared package `vend_pkg`:
  - state encoding constants;
  - coin codes and coin values (1/5/10);
  - widths: money 7, type 3, amount 4.
- One sub-module: `vend_change_gen`.
  - Holds the remainder register and greedy coin selection.
  - Interface: load, step, `coin_code`, empty.
  - Instantiated only under `VEND_CHANGE_EN`.

## Test plan
- Type 3, amount 2, change 17, defaults →
  - two 4-cycle pulses with `motor_sel`=3, separated by 2-cycle gaps;
  - coins 11, 10, 01, 01;
  - `done` in cycle 16.
- Amount 0, change 0 → `done` in cycle 0; `motor_pulse` and `coin_strobe` never asserted.
- Amount 0, change 127 → 12×code 11, 1×code 10, 2×code 01 (15 strobes); `done` in cycle 15.
- `vend_valid` held high throughout →
  - second command accepted only in the `IDLE` cycle after `done`;
  - `vend_ready` is 0 during busy.
- `rst` asserted in the 2nd cycle of a pulse (amount 5) →
  - `motor_pulse`, `busy`, `done` go 0 immediately;
  - `vend_ready`=1 after release;
  - no further pulses.
- Build without `VEND_CHANGE_EN`, amount 1, change 17 → one pulse, no coin strobes; `done` in cycle 6.
